hwpe_stream_fifo_flat_thr: RTL
==============================

// Module: hwpe_stream_fifo_flat_thr
// PURPOSE
//  Flat-port stream FIFO with parametrised width and depth, optional fall-through, occupancy count
//  and programmable almost-full/almost-empty thresholds.
//  Sits between HWPE streamers and engine datapaths, where flat ports are needed (tiles, Verilator tops).
//  Provides the back-pressure look-ahead that a plain empty/full FIFO cannot.
// PARAMETERS
//  DATA_WIDTH        32            payload width in bits; multiple of 8; strb width = DATA_WIDTH/8
//  FIFO_DEPTH        8             number of entries; >=2; need not be a power of 2
//  FALL_THROUGH      0             1: when empty, push data is presented on pop in the same cycle
//  ALMOST_FULL_THR   FIFO_DEPTH-1  almost_full when level >= this value; range 1..FIFO_DEPTH
//  ALMOST_EMPTY_THR  1             almost_empty when level <= this value; range 0..FIFO_DEPTH-1
// PORTS
//  clk                 in   1               clock, all state on rising edge
//  rst                 in   1               synchronous reset, active-high
//  clear               in   1               synchronous flush, active-high
//  push_valid          in   1               upstream word valid
//  push_ready          out  1               FIFO can accept a word
//  push_data           in   DATA_WIDTH      upstream payload
//  push_strb           in   DATA_WIDTH/8    upstream byte strobes
//  pop_valid           out  1               word available downstream
//  pop_ready           in   1               downstream accepts the word
//  pop_data            out  DATA_WIDTH      downstream payload
//  pop_strb            out  DATA_WIDTH/8    downstream byte strobes
//  level               out  LW              stored entries; LW = $clog2(FIFO_DEPTH+1)
//  flags_empty         out  1               level == 0
//  flags_full          out  1               level == FIFO_DEPTH
//  flags_almost_full   out  1               level >= ALMOST_FULL_THR
//  flags_almost_empty  out  1               level <= ALMOST_EMPTY_THR
// BEHAVIOUR
//  - Push handshake: push_valid & push_ready. Pop handshake: pop_valid & pop_ready.
//  - Once valid is asserted, data and strb are held stable until the handshake completes.
//  - push_ready = !flags_full & !clear & !rst; it never depends on pop_ready, so there is no comb path.
//  - Normal mode: pop_valid = !flags_empty & !clear. pop_data/strb come from the storage entry at rd_ptr.
//  - Normal mode latency: a word pushed in cycle N is poppable in cycle N+1.
//  - FALL_THROUGH=1 and flags_empty: pop_valid = push_valid, and pop_data/strb = push_data/strb (comb).
//  - Fall-through with both handshakes in the same cycle: the word bypasses storage; level, pointers unchanged.
//  - pop_data and pop_strb are forced to 0 whenever pop_valid = 0.
//  - Pointers: wr_ptr advances on push into storage, rd_ptr advances on pop from storage.
//  - Pointer wrap: each pointer goes FIFO_DEPTH-1 -> 0.
//  - level: +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds FIFO_DEPTH.
//  - Full + pop_ready: the pop is taken, push_ready stays 0 that cycle, and push is accepted next cycle.
//  - Empty in normal mode: a push is accepted, pop_valid stays 0 until the next cycle.
//  - Flags are combinational from registered level; no extra latency.
//  - rst or clear: pointers and level go to 0 in the next cycle, storage is not reset.
//    Handshakes in that cycle are ignored.
//  - Reset values: push_ready=1 (after rst drops), pop_valid=0, pop_data=0, pop_strb=0, level=0.
//    Flags after reset: empty=1, full=0, almost_full=0, almost_empty=1.
//  - rst or clear in the middle of traffic discards all stored words; there is no partial drain.
//  - Elaboration asserts: FIFO_DEPTH>=2, DATA_WIDTH%8==0, threshold ranges as stated above.
// TESTING
//  - Reset: hold rst 2 cycles with push_valid=1.
//    Expect no word stored, level=0, empty=1, almost_empty=1, pop_data=0.
//  - Fill and drain: DEPTH=8, push 0..7 with pop_ready=0.
//    Expect full=1, level=8, push_ready=0. Then pop all, expect order 0..7 and strb preserved.
//  - Thresholds: AF_THR=6, AE_THR=2, push 1 word/cycle.
//    Expect almost_empty drops at level 3 and almost_full rises at level 6.
//  - Simultaneous ops: at level 8 with both valid/ready, expect pop only and level 7.
//    At level 4 with both, expect level stays 4 and data order is intact.
//  - Wrap and odd depth: DEPTH=5, run 23 random push/pop cycles.
//    Expect scoreboard match, level tracking, and correct pointer wrap 4->0.
//  - Fall-through and clear: FT=1 empty, push 0xA5 with pop_ready=1.
//    Expect same-cycle pop 0xA5 and level 0. Then store 3 words and clear: level=0, pop_valid=0.

Source files
------------

// File: rtl/hwpe_stream_fifo_flat_thr.sv
// Flat-port stream FIFO with occupancy level, almost-full/almost-empty thresholds
// and an optional fall-through bypass when empty.
module hwpe_stream_fifo_flat_thr #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned FALL_THROUGH     = 0,
  parameter int unsigned ALMOST_FULL_THR  = FIFO_DEPTH - 1,
  parameter int unsigned ALMOST_EMPTY_THR = 1,
  localparam int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
  localparam int unsigned LW              = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [STRB_WIDTH-1:0] push_strb,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [STRB_WIDTH-1:0] pop_strb,
  output logic [LW-1:0]         level,
  output logic                  flags_empty,
  output logic                  flags_full,
  output logic                  flags_almost_full,
  output logic                  flags_almost_empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  generate
    if (FIFO_DEPTH < 2) begin : g_err_depth
      $error("FIFO_DEPTH must be >= 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_err_width
      $error("DATA_WIDTH must be a multiple of 8");
    end
    if (ALMOST_FULL_THR < 1 || ALMOST_FULL_THR > FIFO_DEPTH) begin : g_err_af
      $error("ALMOST_FULL_THR out of range 1..FIFO_DEPTH");
    end
    if (ALMOST_EMPTY_THR > FIFO_DEPTH - 1) begin : g_err_ae
      $error("ALMOST_EMPTY_THR out of range 0..FIFO_DEPTH-1");
    end
  endgenerate

  typedef struct packed {
    logic [STRB_WIDTH-1:0] strb;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          flush, bypass, push_hs, pop_hs, wr_en, rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign flush              = rst | clear;
  assign level              = level_q;
  assign flags_empty        = (level_q == '0);
  assign flags_full         = (level_q == LW'(FIFO_DEPTH));
  assign flags_almost_full  = (level_q >= LW'(ALMOST_FULL_THR));
  assign flags_almost_empty = (level_q <= LW'(ALMOST_EMPTY_THR));

  // Bypass only exists when storage is empty, so order is never violated.
  assign bypass     = (FALL_THROUGH != 0) && flags_empty;
  assign push_ready = !flags_full & !flush;
  assign pop_valid  = !flush & (bypass ? push_valid : !flags_empty);
  assign push_hs    = push_valid & push_ready;
  assign pop_hs     = pop_valid & pop_ready;
  assign wr_en      = push_hs & !(bypass & pop_hs);
  assign rd_en      = pop_hs & !bypass;

  always_comb begin
    pop_data = '0;
    pop_strb = '0;
    if (pop_valid) begin
      if (bypass) begin
        pop_data = push_data;
        pop_strb = push_strb;
      end else begin
        pop_data = mem_q[rd_ptr_q].data;
        pop_strb = mem_q[rd_ptr_q].strb;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q;
    if (wr_en && !rd_en)      level_d = level_q + LW'(1);
    else if (rd_en && !wr_en) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is intentionally left unreset; wr_en is already blocked by rst/clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q].data <= push_data;
      mem_q[wr_ptr_q].strb <= push_strb;
    end
  end

endmodule
